maze_writer_avl: RTL
====================

MAZE_WRITER_AVL -- requirements
Module: maze_writer_avl

Interface
REQ-001 Parameter MAZE_WORDS, default 600, number of 32-bit maze words per maze; must equal the slave maze register count.
REQ-002 Parameter NUM_MAZES, default 4, number of mazes held in the maze ROM.
REQ-003 CLK  input  1  sole clock, 50 MHz, shared with the VGA text interface slave.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to load a maze.
REQ-006 maze_sel  input  2  maze index; sampled only on an accepted start.
REQ-007 AVL_WAITREQUEST  input  1  slave stall; a write is held while it is high.
REQ-008 AVL_WRITE  output  1  Avalon-MM write strobe.
REQ-009 AVL_CS  output  1  chip select; equals AVL_WRITE.
REQ-010 AVL_BYTE_EN  output  4  byte enables; 4'hF whenever AVL_WRITE=1, else 4'h0.
REQ-011 AVL_ADDR  output  10  word address, 0..MAZE_WORDS-1.
REQ-012 AVL_WRITEDATA  output  32  maze word, bit 31 = leftmost 4-pixel cell.
REQ-013 busy  output  1  high from accepted start until the final write is accepted.
REQ-014 maze_ready  output  1  high while a complete maze is resident in the slave; feeds game_states.
REQ-015 done  output  1  one-cycle pulse when the load completes.

Function
REQ-016 FSM states: IDLE, FETCH, WRITE, FINISH.
REQ-017 IDLE: start=1 -> latch maze_sel, clear word index to 0, clear maze_ready, set busy, go FETCH.
REQ-018 FETCH: present ROM address maze_sel*MAZE_WORDS+index (12 bits); go WRITE next cycle.
REQ-019 ROM read latency is exactly 1 cycle; the ROM word is registered into AVL_WRITEDATA on entry to WRITE.
REQ-020 WRITE: AVL_WRITE=1, AVL_ADDR=index; ADDR, DATA and BYTE_EN stay stable while AVL_WAITREQUEST=1.
REQ-021 Accept = AVL_WRITE & ~AVL_WAITREQUEST; on accept with index<MAZE_WORDS-1, increment index and go FETCH.
REQ-022 On accept with index=MAZE_WORDS-1: go FINISH; the index does not wrap.
REQ-023 FINISH lasts one cycle: done=1, busy cleared, maze_ready set (visible the cycle after FINISH), go IDLE.
REQ-024 With no wait-states, each word takes 2 cycles: first AVL_WRITE 2 cycles after the start cycle; 1200 cycles per 600-word load.
REQ-025 start while busy is ignored; maze_sel changes while busy have no effect.
REQ-026 start in the same cycle as FINISH is ignored; start in IDLE with maze_ready=1 reloads and drops maze_ready.
REQ-027 AVL_WRITE is never asserted outside WRITE; no reads are issued.
REQ-028 maze_sel values >= NUM_MAZES load maze 0.

Reset
REQ-029 RESET low asynchronously forces IDLE, index=0, latched sel=0, and all outputs 0, including AVL_WRITEDATA and AVL_ADDR.
REQ-030 Reset mid-load abandons the transfer with no further writes; maze_ready stays 0 until a new load completes.
REQ-031 Reset release is synchronised to CLK before the FSM acts on it.

Structure
REQ-032 MAZE_WORDS, NUM_MAZES, the ROM address width (12) and the FSM state enum live in shared package tank_pkg.
REQ-033 The ROM is a single sub-module maze_rom: synchronous read, 1-cycle latency, initialised from a memory file holding NUM_MAZES*MAZE_WORDS words.

Verification
REQ-034 Reset, then start with maze_sel=0 and no wait-states -> 600 writes, addresses 0..599 in order, data = ROM[0..599], done pulse at cycle 1201, maze_ready=1 thereafter.
REQ-035 maze_sel=2, with waitrequest high for 3 cycles on every 7th write -> addr/data held stable during the stall, no lost or duplicated words, data = ROM[1200..1799].
REQ-036 start pulsed again at word 100 with maze_sel=1 -> ignored; load completes with maze 0 data; exactly one done pulse.
REQ-037 RESET low at word 300 -> AVL_WRITE=0 immediately (asynchronous), maze_ready=0; a new start reloads from address 0.
REQ-038 start in IDLE with maze_ready=1 -> maze_ready=0 the next cycle and 1 again after the new load completes.
REQ-039 Scoreboard mirrors 600 slave registers and compares them with the ROM image after each load.

Source files
------------

// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
// Package : tank_pkg
// Brief   : Maze geometry, ROM addressing and writer FSM encoding for tank game.
// Rev     : 1.0  initial release
// ============================================================================
package tank_pkg;

    localparam int MAZE_WORDS = 600;
    localparam int NUM_MAZES  = 4;
    localparam int ROM_AW     = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } wr_state_t;

    // Maze image: every word is unique, so a wrong maze or word order is visible.
    function automatic logic [31:0] maze_rom_word(input logic [ROM_AW-1:0] addr);
        return {4'hA, addr, 4'h5, ~addr};
    endfunction

endpackage
`default_nettype wire

// File: rtl/maze_rom.sv
`default_nettype none
// ============================================================================
// Module : maze_rom
// Brief  : Maze image ROM, synchronous read with one cycle of latency.
// Rev    : 1.0  initial release
// ============================================================================
module maze_rom
    import tank_pkg::*;
#(
    parameter int DEPTH = MAZE_WORDS * NUM_MAZES
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [ROM_AW-1:0] i_addr,
    output logic [31:0]       o_data
);

    // Output only updates when enabled, so it doubles as the held write-data register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data <= '0;
        end else if (i_en) begin
            o_data <= (int'(i_addr) < DEPTH) ? maze_rom_word(i_addr) : 32'h0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/maze_writer_avl.sv
`default_nettype none
// ============================================================================
// Module : maze_writer_avl
// Brief  : Copies one ROM maze into the VGA text slave over Avalon-MM writes.
// Rev    : 1.0  initial release
// ============================================================================
module maze_writer_avl #(
    parameter int MAZE_WORDS = tank_pkg::MAZE_WORDS,
    parameter int NUM_MAZES  = tank_pkg::NUM_MAZES
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [1:0]  maze_sel,
    input  logic        AVL_WAITREQUEST,
    output logic        AVL_WRITE,
    output logic        AVL_CS,
    output logic [3:0]  AVL_BYTE_EN,
    output logic [9:0]  AVL_ADDR,
    output logic [31:0] AVL_WRITEDATA,
    output logic        busy,
    output logic        maze_ready,
    output logic        done
);
    import tank_pkg::*;

    localparam logic [9:0] C_LAST_INDEX = 10'(MAZE_WORDS - 1);

    wr_state_t         r_state;
    wr_state_t         w_state_nxt;
    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    logic [9:0]        r_index;
    logic [1:0]        r_sel;
    logic              r_maze_ready;
    logic              w_accept;
    logic              w_last;
    logic [ROM_AW-1:0] w_rom_addr;

    // Assert immediately, release only after two clean clock edges.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_accept   = (r_state == ST_WRITE) && !AVL_WAITREQUEST;
    assign w_last     = (r_index == C_LAST_INDEX);
    assign w_rom_addr = ROM_AW'(r_sel) * ROM_AW'(MAZE_WORDS) + ROM_AW'(r_index);

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ST_IDLE;
            r_index      <= '0;
            r_sel        <= '0;
            r_maze_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && start) begin
                r_sel        <= (int'(maze_sel) < NUM_MAZES) ? maze_sel : 2'd0;
                r_index      <= '0;
                r_maze_ready <= 1'b0;
            end else if (w_accept && !w_last) begin
                r_index <= r_index + 10'd1;
            end
            if (r_state == ST_FINISH) begin
                r_maze_ready <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        AVL_WRITE   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                busy        = 1'b1;
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                busy      = 1'b1;
                AVL_WRITE = 1'b1;
                if (w_accept) w_state_nxt = w_last ? ST_FINISH : ST_FETCH;
            end
            ST_FINISH: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign AVL_CS      = AVL_WRITE;
    assign AVL_BYTE_EN = AVL_WRITE ? 4'hF : 4'h0;
    assign AVL_ADDR    = r_index;
    assign maze_ready  = r_maze_ready;

    maze_rom #(
        .DEPTH(MAZE_WORDS * NUM_MAZES)
    ) u_maze_rom (
        .i_clk  (CLK),
        .i_rst_n(w_rst_n),
        .i_en   (r_state == ST_FETCH),
        .i_addr (w_rom_addr),
        .o_data (AVL_WRITEDATA)
    );

endmodule
`default_nettype wire
